multicycle_control: RTL
=======================

# multicycle_control

Main control FSM for the multicycle MIPS datapath. Sequences each instruction through fetch, decode, execute, memory and writeback, and drives every datapath enable and mux select. Produces the 2-bit `aluop` consumed by `alu_control`. Stalls memory states on a `mem_ready` handshake from the unified instruction/data memory.

## Interface
- No parameters.
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- opcode  input  6  instruction register bits [31:26]
- zero  input  1  ALU zero flag (used only for the `beq` decision)
- mem_ready  input  1  memory completes the current read or write this cycle
- pcwrite  output  1  unconditional PC load
- pcwritecond  output  1  PC load qualified by `zero` in the datapath
- iord  output  1  memory address select: 0 = PC, 1 = ALUOut
- memread  output  1  memory read request
- memwrite  output  1  memory write request
- irwrite  output  1  instruction register load
- memtoreg  output  1  register-file write data select: 1 = MDR, 0 = ALUOut
- regdst  output  1  destination register select: 1 = rd, 0 = rt
- regwrite  output  1  register-file write enable
- alusrca  output  1  ALU A select: 0 = PC, 1 = rs
- alusrcb  output  2  ALU B select: 00 = rt, 01 = 4, 10 = sign-extended imm, 11 = imm<<2
- pcsrc  output  2  PC source select: 00 = ALU result, 01 = ALUOut, 10 = jump target
- aluop  output  2  to `alu_control`: 00 add, 01 sub, 10 funct, 11 add (immediate)
- illegal_op  output  1  unrecognised opcode seen in DECODE
- retire  output  1  one-cycle pulse when an instruction completes
- state  output  4  current FSM state (debug)

## Operation
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11. Codes 12–15 go to FETCH on the next edge, with all outputs 0 while in them.
- Recognised opcodes:
  - R-type 0x00
  - lw 0x23
  - sw 0x2B
  - beq 0x04
  - j 0x02
  - addi 0x08
- Outputs are Moore, decoded from `state`. The exceptions are the `mem_ready`-qualified strobes and `illegal_op`, which are combinational. Every output not listed for a state is 0.
- Per-state outputs and transitions:
  - FETCH: memread=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00. irwrite and pcwrite each equal mem_ready. Goes to DECODE when mem_ready=1, otherwise stays.
  - DECODE: alusrca=0, alusrcb=11, aluop=00. Next state by opcode:
    - lw/sw → MEMADR
    - R → RTYPEEX
    - beq → BEQEX
    - addi → ADDIEX
    - j → JEX
    - any other opcode → FETCH, with illegal_op=1 this cycle
  - MEMADR: alusrca=1, alusrcb=10, aluop=00. Goes to MEMRD for lw, MEMWR for sw.
  - MEMRD: memread=1, iord=1. Goes to MEMWB when mem_ready=1, otherwise holds.
  - MEMWB: regwrite=1, memtoreg=1, regdst=0, retire=1. Goes to FETCH.
  - MEMWR: memwrite=1, iord=1. Goes to FETCH when mem_ready=1, with retire=mem_ready. Otherwise holds.
  - RTYPEEX: alusrca=1, alusrcb=00, aluop=10. Goes to RTYPEWB.
  - RTYPEWB: regwrite=1, regdst=1, memtoreg=0, retire=1. Goes to FETCH.
  - BEQEX: alusrca=1, alusrcb=00, aluop=01, pcwritecond=1, pcsrc=01, retire=1. Goes to FETCH. The block ignores `zero` internally; the datapath gates the PC load with it.
  - ADDIEX: alusrca=1, alusrcb=10, aluop=11. Goes to ADDIWB.
  - ADDIWB: regwrite=1, regdst=0, memtoreg=0, retire=1. Goes to FETCH.
  - JEX: pcwrite=1, pcsrc=10, retire=1. Goes to FETCH.
- Memory requests (memread/memwrite with iord) are held constant for the whole time a state waits on mem_ready.

## Timing
- Reset: while rst=1 at a rising edge, state ← FETCH. While rst is high, every output except `state` is forced to 0, so no memory request or write enable is issued during reset. Reset asserted mid-instruction aborts it: no regwrite and no retire.
- First fetch request appears in the first cycle after rst deasserts.
- Latency with zero wait states (mem_ready=1 on first request), counting edges from entering FETCH to returning to FETCH:
  - j, beq: 3
  - R-type, addi: 4
  - sw: 4
  - lw: 5
- Each cycle mem_ready is low in FETCH, MEMRD or MEMWR adds one cycle.
- mem_ready is ignored in every other state.
- opcode must be stable from DECODE to retire; it is sampled only in DECODE and MEMADR.
- retire fires exactly once per completed legal instruction and never for an illegal opcode.

## Test plan
- Reset: hold rst 3 cycles with mem_ready=1 → all strobes 0 and state=0. First cycle after release: memread=1, pcwrite=1, irwrite=1.
- R-type, opcode 0x00, mem_ready=1 → state sequence 0,1,6,7,0; aluop=10 in RTYPEEX; regwrite=1 and regdst=1 in RTYPEWB; one retire pulse.
- lw 0x23 with mem_ready low for 2 cycles in MEMRD → sequence 0,1,2,3,3,3,4,0; iord=1 and memread=1 held throughout MEMRD; memtoreg=1 and regwrite=1 in MEMWB.
- sw 0x2B with mem_ready low for 3 cycles in FETCH → FETCH held 4 cycles with irwrite=0 until mem_ready; then 1,2,5,0; memwrite=1 only in MEMWR.
- beq 0x04 → BEQEX with aluop=01, pcwritecond=1, pcsrc=01. j 0x02 → JEX with pcwrite=1, pcsrc=10. addi 0x08 → aluop=11 in ADDIEX.
- Opcode 0x3F in DECODE → illegal_op=1 for one cycle, returns to FETCH, no retire. Separately, assert rst during MEMRD → next state FETCH with regwrite never asserted.

Source files
------------

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch/decode/execute/
// memory/writeback and decodes every datapath enable and mux select from the state.
module multicycle_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       pcwritecond,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       memtoreg,
  output logic       regdst,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic       illegal_op,
  output logic       retire,
  output logic [3:0] state
);

  localparam logic [3:0] FETCH   = 4'd0;
  localparam logic [3:0] DECODE  = 4'd1;
  localparam logic [3:0] MEMADR  = 4'd2;
  localparam logic [3:0] MEMRD   = 4'd3;
  localparam logic [3:0] MEMWB   = 4'd4;
  localparam logic [3:0] MEMWR   = 4'd5;
  localparam logic [3:0] RTYPEEX = 4'd6;
  localparam logic [3:0] RTYPEWB = 4'd7;
  localparam logic [3:0] BEQEX   = 4'd8;
  localparam logic [3:0] ADDIEX  = 4'd9;
  localparam logic [3:0] ADDIWB  = 4'd10;
  localparam logic [3:0] JEX     = 4'd11;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_ADDI = 6'h08;

  logic [3:0] next_state;

  // The branch decision is made in the datapath by gating pcwritecond with zero.
  logic unused_zero;
  assign unused_zero = zero;

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= next_state;
  end

  always_comb begin
    next_state = FETCH;
    case (state)
      FETCH:   next_state = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_R:         next_state = RTYPEEX;
          OP_BEQ:       next_state = BEQEX;
          OP_ADDI:      next_state = ADDIEX;
          OP_J:         next_state = JEX;
          default:      next_state = FETCH;
        endcase
      end
      MEMADR: begin
        if (opcode == OP_LW)      next_state = MEMRD;
        else if (opcode == OP_SW) next_state = MEMWR;
        else                      next_state = FETCH;
      end
      MEMRD:   next_state = mem_ready ? MEMWB : MEMRD;
      MEMWR:   next_state = mem_ready ? FETCH : MEMWR;
      RTYPEEX: next_state = RTYPEWB;
      ADDIEX:  next_state = ADDIWB;
      default: next_state = FETCH;
    endcase
  end

  always_comb begin
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    iord        = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    memtoreg    = 1'b0;
    regdst      = 1'b0;
    regwrite    = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    pcsrc       = 2'b00;
    aluop       = 2'b00;
    illegal_op  = 1'b0;
    retire      = 1'b0;
    case (state)
      FETCH: begin
        memread = 1'b1;
        alusrcb = 2'b01;
        irwrite = mem_ready;
        pcwrite = mem_ready;
      end
      DECODE: begin
        alusrcb = 2'b11;
        case (opcode)
          OP_LW, OP_SW, OP_R, OP_BEQ, OP_ADDI, OP_J: illegal_op = 1'b0;
          default:                                   illegal_op = 1'b1;
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
      end
      MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
        retire   = 1'b1;
      end
      MEMWR: begin
        memwrite = 1'b1;
        iord     = 1'b1;
        retire   = mem_ready;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      RTYPEWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
        retire   = 1'b1;
      end
      BEQEX: begin
        alusrca     = 1'b1;
        aluop       = 2'b01;
        pcwritecond = 1'b1;
        pcsrc       = 2'b01;
        retire      = 1'b1;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        aluop   = 2'b11;
      end
      ADDIWB: begin
        regwrite = 1'b1;
        retire   = 1'b1;
      end
      JEX: begin
        pcwrite = 1'b1;
        pcsrc   = 2'b10;
        retire  = 1'b1;
      end
      default: ;
    endcase
    // Reset masks every request and write enable so an aborted instruction has no effect.
    if (rst) begin
      pcwrite     = 1'b0;
      pcwritecond = 1'b0;
      iord        = 1'b0;
      memread     = 1'b0;
      memwrite    = 1'b0;
      irwrite     = 1'b0;
      memtoreg    = 1'b0;
      regdst      = 1'b0;
      regwrite    = 1'b0;
      alusrca     = 1'b0;
      alusrcb     = 2'b00;
      pcsrc       = 2'b00;
      aluop       = 2'b00;
      illegal_op  = 1'b0;
      retire      = 1'b0;
    end
  end

endmodule
